// File: rtl/rv3n_branch_reporter_pkg.sv
// Shared widths and the queued branch record for the branch reporter.
package rv3n_branch_reporter_pkg;

  localparam int INUM      = 2;
  localparam int XLEN      = 32;
  localparam int RPT_DEPTH = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            predict;
    logic            taken;
  } br_entry_t;

endpackage

// File: rtl/rv3n_rpt_fifo.sv
// Circular buffer taking up to INUM pre-compacted writes per cycle and one read.
module rv3n_rpt_fifo
  import rv3n_branch_reporter_pkg::*;
#(
  parameter int DEPTH = RPT_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          pop,
  input  logic [CW-1:0] push_n,
  input  br_entry_t     wdata [INUM],
  output br_entry_t     head,
  output logic [CW-1:0] count
);

  br_entry_t     mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Writes are already compacted: slot i lands i entries past wr_ptr.
      for (int i = 0; i < INUM; i++) begin
        if (CW'(i) < push_n) mem[wr_ptr + PW'(i)] <= wdata[i];
      end
      wr_ptr <= wr_ptr + PW'(push_n);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + push_n - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/rv3n_branch_reporter.sv
// Queues resolved conditional branches from commit and drains one per cycle to the predictor.
module rv3n_branch_reporter
  import rv3n_branch_reporter_pkg::*;
#(
  parameter int DEPTH  = RPT_DEPTH,
  parameter int CNT_W  = 32,
  parameter int DROP_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [INUM-1:0]      cm_br_vld,
  input  logic [XLEN*INUM-1:0] cm_br_pc,
  input  logic [INUM-1:0]      cm_br_predict,
  input  logic [INUM-1:0]      cm_br_taken,
  output logic                 ch2predictor_valid,
  output logic [XLEN-1:0]      ch2predictor_pc,
  output logic                 ch2predictor_predict,
  output logic                 ch2predictor_taken,
  output logic                 rpt_full,
  output logic [DROP_W-1:0]    rpt_drop_cnt,
  output logic [CNT_W-1:0]     rpt_br_cnt,
  output logic [CNT_W-1:0]     rpt_miss_cnt
);

  localparam int CW = $clog2(DEPTH + 1);

  br_entry_t     comp [INUM];
  br_entry_t     head;
  logic [CW-1:0] count;
  logic [CW-1:0] push_n;
  logic [CW-1:0] n_drop;
  logic          pop;
  logic [DROP_W:0] drop_sum;

  // Update channel is valid-only: the predictor takes every cycle valid is high, there is no ready.
  assign pop = (count != '0) && !clr;

  always_comb begin
    int rank;
    int nv;
    int free;
    int n_acc;
    rank  = 0;
    nv    = 0;
    free  = 0;
    n_acc = 0;
    for (int j = 0; j < INUM; j++) comp[j] = '0;
    for (int k = 0; k < INUM; k++) begin
      rank = 0;
      for (int m = 0; m < k; m++) rank += int'(cm_br_vld[m]);
      for (int j = 0; j < INUM; j++) begin
        if (cm_br_vld[k] && rank == j) begin
          comp[j].pc      = cm_br_pc[k*XLEN +: XLEN];
          comp[j].predict = cm_br_predict[k];
          comp[j].taken   = cm_br_taken[k];
        end
      end
      nv += int'(cm_br_vld[k]);
    end
    // A slot popped this cycle is reusable by this cycle's push.
    free   = DEPTH - int'(count) + int'(pop);
    n_acc  = clr ? 0 : ((nv < free) ? nv : free);
    push_n = CW'(n_acc);
    n_drop = clr ? '0 : CW'(nv - n_acc);
  end

  rv3n_rpt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .pop    (pop),
    .push_n (push_n),
    .wdata  (comp),
    .head   (head),
    .count  (count)
  );

  always_comb begin
    ch2predictor_valid   = pop;
    ch2predictor_pc      = pop ? head.pc : '0;
    ch2predictor_predict = pop ? head.predict : 1'b0;
    ch2predictor_taken   = pop ? head.taken : 1'b0;
  end

  assign rpt_full = (count == CW'(DEPTH));
  assign drop_sum = {1'b0, rpt_drop_cnt} + (DROP_W+1)'(n_drop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_drop_cnt <= '0;
      rpt_br_cnt   <= '0;
      rpt_miss_cnt <= '0;
    end else begin
      rpt_drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      if (pop) begin
        rpt_br_cnt <= rpt_br_cnt + 1'b1;
        if (head.predict != head.taken) rpt_miss_cnt <= rpt_miss_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv3n_branch_reporter.sv
// Directed and random checks of rv3n_branch_reporter against a queue-based reference model.
module tb_rv3n_branch_reporter;

  localparam int DEPTH  = 4;
  localparam int CNT_W  = 32;
  localparam int DROP_W = 16;
  localparam int XLEN   = 32;

  logic              clk;
  logic              rst;
  logic              clr;
  logic [1:0]        cm_br_vld;
  logic [2*XLEN-1:0] cm_br_pc;
  logic [1:0]        cm_br_predict;
  logic [1:0]        cm_br_taken;
  logic              ch2predictor_valid;
  logic [XLEN-1:0]   ch2predictor_pc;
  logic              ch2predictor_predict;
  logic              ch2predictor_taken;
  logic              rpt_full;
  logic [DROP_W-1:0] rpt_drop_cnt;
  logic [CNT_W-1:0]  rpt_br_cnt;
  logic [CNT_W-1:0]  rpt_miss_cnt;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b1;

  // Reference model: entry = {pc, predict, taken}
  logic [XLEN+1:0] exp_q[$];
  int              m_drop = 0;
  logic [CNT_W-1:0] m_br   = '0;
  logic [CNT_W-1:0] m_miss = '0;

  rv3n_branch_reporter #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DROP_W(DROP_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .clr                  (clr),
    .cm_br_vld            (cm_br_vld),
    .cm_br_pc             (cm_br_pc),
    .cm_br_predict        (cm_br_predict),
    .cm_br_taken          (cm_br_taken),
    .ch2predictor_valid   (ch2predictor_valid),
    .ch2predictor_pc      (ch2predictor_pc),
    .ch2predictor_predict (ch2predictor_predict),
    .ch2predictor_taken   (ch2predictor_taken),
    .rpt_full             (rpt_full),
    .rpt_drop_cnt         (rpt_drop_cnt),
    .rpt_br_cnt           (rpt_br_cnt),
    .rpt_miss_cnt         (rpt_miss_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_drop = 0;
    m_br   = '0;
    m_miss = '0;
  endtask

  // Drive one cycle, compare outputs against the model, then advance the model.
  task automatic do_cycle(input logic [1:0] vld, input logic [31:0] pc0, input logic [31:0] pc1,
                          input logic [1:0] pr, input logic [1:0] tk, input logic c);
    logic            exp_v;
    logic [XLEN+1:0] e;
    logic [XLEN+1:0] hd;
    cm_br_vld     = vld;
    cm_br_pc      = {pc1, pc0};
    cm_br_predict = pr;
    cm_br_taken   = tk;
    clr           = c;
    @(negedge clk);
    if (check_en) begin
      exp_v = !c && (exp_q.size() != 0);
      hd    = exp_v ? exp_q[0] : '0;
      chk("valid",    ch2predictor_valid,   exp_v);
      chk("pc",       ch2predictor_pc,      hd[XLEN+1:2]);
      chk("predict",  ch2predictor_predict, hd[1]);
      chk("taken",    ch2predictor_taken,   hd[0]);
      chk("full",     rpt_full,             exp_q.size() == DEPTH);
      chk("drop_cnt", rpt_drop_cnt,         m_drop);
      chk("br_cnt",   rpt_br_cnt,           m_br);
      chk("miss_cnt", rpt_miss_cnt,         m_miss);
    end
    if (c) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        m_br++;
        if (e[1] != e[0]) m_miss++;
      end
      for (int l = 0; l < 2; l++) begin
        if (vld[l]) begin
          if (exp_q.size() < DEPTH) exp_q.push_back({(l == 0) ? pc0 : pc1, pr[l], tk[l]});
          else if (m_drop < 65535) m_drop++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(2'b00, 0, 0, 2'b00, 2'b00, 1'b0);
  endtask

  initial begin
    logic [DROP_W-1:0] drop_save;
    logic [CNT_W-1:0]  br_save;
    logic [31:0]       pc;

    rst = 1'b1; clr = 1'b0; cm_br_vld = '0; cm_br_pc = '0; cm_br_predict = '0; cm_br_taken = '0;
    model_reset();
    #12;
    chk("rst_valid", ch2predictor_valid, 1'b0);
    chk("rst_pc",    ch2predictor_pc,    32'h0);
    chk("rst_full",  rpt_full,           1'b0);
    chk("rst_drop",  rpt_drop_cnt,       16'h0);
    chk("rst_br",    rpt_br_cnt,         32'h0);
    chk("rst_miss",  rpt_miss_cnt,       32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single lane, mispredicted
    do_cycle(2'b01, 32'h100, 32'h0, 2'b00, 2'b01, 1'b0);
    do_cycle(2'b00, 0, 0, 2'b00, 2'b00, 1'b0);
    do_cycle(2'b00, 0, 0, 2'b00, 2'b00, 1'b0);
    chk("single_br",   rpt_br_cnt,   32'd1);
    chk("single_miss", rpt_miss_cnt, 32'd1);

    // Two lanes in one cycle drain in lane order
    do_cycle(2'b11, 32'h200, 32'h204, 2'b10, 2'b10, 1'b0);
    idle(3);

    // Overflow: steady pushes of two lanes while draining one
    for (int i = 0; i < 6; i++) do_cycle(2'b11, 32'h1000 + i*8, 32'h1004 + i*8, 2'b01, 2'b11, 1'b0);
    idle(1);
    chk("ovf_drop", rpt_drop_cnt, 16'd3);
    idle(DEPTH + 1);

    // Fill, then one lane per cycle at full for three pointer laps
    for (int i = 0; i < 3; i++) do_cycle(2'b11, 32'h2000 + i*8, 32'h2004 + i*8, 2'b00, 2'b00, 1'b0);
    drop_save = rpt_drop_cnt;
    for (int i = 0; i < 3*DEPTH; i++) do_cycle(2'b01, 32'h3000 + i*4, 0, 2'b01, 2'b00, 1'b0);
    chk("lap_full", rpt_full,     1'b1);
    chk("lap_drop", rpt_drop_cnt, drop_save);
    idle(DEPTH + 1);

    // clr with three entries held and both lanes pushing
    do_cycle(2'b11, 32'h4000, 32'h4004, 2'b00, 2'b00, 1'b0);
    do_cycle(2'b11, 32'h4008, 32'h400c, 2'b00, 2'b00, 1'b0);
    drop_save = rpt_drop_cnt;
    br_save   = rpt_br_cnt;
    do_cycle(2'b11, 32'h4010, 32'h4014, 2'b00, 2'b00, 1'b1);
    chk("clr_valid", ch2predictor_valid, 1'b0);
    chk("clr_drop",  rpt_drop_cnt,       drop_save);
    chk("clr_br",    rpt_br_cnt,         br_save);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      pc = $urandom;
      do_cycle(2'($urandom_range(0, 3)), {pc[31:2], 2'b00}, $urandom & 32'hffff_fffc,
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset in the middle of a cycle with entries pending
    do_cycle(2'b11, 32'h5000, 32'h5004, 2'b11, 2'b00, 1'b0);
    cm_br_vld = 2'b00;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", ch2predictor_valid, 1'b0);
    chk("arst_full",  rpt_full,           1'b0);
    chk("arst_drop",  rpt_drop_cnt,       16'h0);
    chk("arst_br",    rpt_br_cnt,         32'h0);
    chk("arst_miss",  rpt_miss_cnt,       32'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Drop counter saturation
    check_en = 1'b0;
    for (int i = 0; i < 65600; i++) do_cycle(2'b11, 32'h6000, 32'h6004, 2'b00, 2'b00, 1'b0);
    check_en = 1'b1;
    do_cycle(2'b11, 32'h6000, 32'h6004, 2'b00, 2'b00, 1'b0);
    chk("drop_sat", rpt_drop_cnt, 16'hFFFF);
    idle(DEPTH + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
